// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver: scanned multi-digit 7-segment driver with blanking, LZ suppression and frame-synchronous updates
//   clk, reset         rising-edge clock, synchronous active-high reset
//   value              packed hex nibbles, digit 0 in bits [3:0]
//   dp_in / digit_en   per-digit decimal point (1 = lit) and enable
//   load               capture value/dp_in/digit_en into pending regs
//   seg, dp, an        registered display pins, polarity set by parameters
//   digit_idx          slot currently scanned
//   frame_done         high during the last cycle of a frame (scan about to wrap to digit 0)
module sevenseg_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, pend_en, disp_en;
    logic                    slot_end, wrap, z, blank;
    logic [NUM_DIGITS-1:0]   lz, sel;
    logic [3:0]              nib;
    logic [6:0]              pat;

    // Active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end   = cnt == CW'(REFRESH_DIV - 1);
        wrap       = slot_end && digit_idx == IW'(NUM_DIGITS - 1);
        frame_done = wrap;
        nib        = disp_val[{digit_idx, 2'b00} +: 4];
        pat        = hex7(nib);
        // lz[k]: nibbles k..top are all zero
        z = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z     = z && disp_val[4*i +: 4] == 4'h0;
            lz[i] = z;
        end
        blank = !disp_en[digit_idx] || (LZ_BLANK != 0 && digit_idx != '0 && lz[digit_idx]);
        sel = '0;
        sel[digit_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            digit_idx <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                digit_idx <= wrap ? '0 : digit_idx + 1'b1;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_en  <= digit_en;
            end
            // Display data only changes at the frame wrap; a coincident load bypasses pending
            if (wrap) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp_in : pend_dp;
                disp_en  <= load ? digit_en : pend_en;
            end
            // seg/dp already show the new digit during the anode blanking window
            seg <= blank ? SEG_OFF : pat ^ ~SEG_OFF;
            dp  <= blank ? DP_OFF : disp_dp[digit_idx] ^ DP_OFF;
            an  <= (blank || cnt < CW'(BLANK_CYCLES)) ? AN_OFF : sel ^ AN_OFF;
        end
    end
endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// tb_sevenseg_mux_driver: scoreboard bench for sevenseg_mux_driver against a frame-level reference model
module tb_sevenseg_mux_driver;
    logic        clk, reset, load, dp, frame_done;
    logic [15:0] value;
    logic [3:0]  dp_in, digit_en, an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;

    sevenseg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference: cycle position st since reset; a frame is 16 cycles, 4 slots of 4 cycles
    int          st = 0;
    logic [15:0] pv = 0, mv = 0;
    logic [3:0]  pdp = 0, mdp = 0, pen = 0, men = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        exp_t e;
        int   k, ph;
        logic bl;
        @(posedge clk);
        if (reset) begin
            st = 0; pv = 0; mv = 0; pdp = 0; mdp = 0; pen = 0; men = 0;
            e = '{seg: 7'h7f, dp: 1'b1, an: 4'hf, idx: 2'd0, fd: 1'b0};
        end else begin
            k  = (st / 4) % 4;
            ph = st % 4;
            bl = !men[k] || (k > 0 && (mv >> (4 * k)) == 16'h0);
            e.seg = bl ? 7'h7f : lut[int'((mv >> (4 * k)) & 16'hf)];
            e.dp  = bl ? 1'b1 : !mdp[k];
            e.an  = (bl || ph < 1) ? 4'hf : ~(4'b0001 << k);
            if (load) begin pv = value; pdp = dp_in; pen = digit_en; end
            if (st % 16 == 15) begin mv = pv; mdp = pdp; men = pen; end
            st++;
            e.idx = 2'((st / 4) % 4);
            e.fd  = (st % 16) == 15;
        end
        q.push_back(e);
    end

    initial forever begin
        exp_t e, g;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            g = '{seg: seg, dp: dp, an: an, idx: digit_idx, fd: frame_done};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got seg=%b dp=%b an=%b idx=%0d fd=%b, want seg=%b dp=%b an=%b idx=%0d fd=%b",
                         $time, g.seg, g.dp, g.an, g.idx, g.fd, e.seg, e.dp, e.an, e.idx, e.fd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
        value = v; digit_en = en; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 40 && st % 16 != p; i++) tick();
        n_chk++;
        if (st % 16 != p) begin
            n_fail++;
            $display("FAIL wait_pos got %0d want %0d", st % 16, p);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        do_load(16'h12af, 4'hf, 4'h0);
        repeat (40) tick();
        do_load(16'h0040, 4'hf, 4'h0);
        repeat (32) tick();
        do_load(16'h0000, 4'hf, 4'h0);
        repeat (32) tick();
        wait_pos(5);
        do_load(16'h1111, 4'hf, 4'h0);
        tick();
        do_load(16'h2222, 4'hf, 4'h0);
        repeat (36) tick();
        wait_pos(15);
        do_load(16'h3456, 4'hf, 4'h5);
        repeat (20) tick();
        do_load(16'h5678, 4'b1010, 4'b0010);
        repeat (36) tick();
        wait_pos(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (40) tick();
        repeat (400) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else if (r < 20)
                do_load($urandom_range(0, 1) ? 16'($urandom & 32'h00ff) : 16'($urandom),
                        4'($urandom), 4'($urandom));
            else
                tick();
        end
        repeat (3) tick();
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
